pipe_run_ctrl: RTL and testbench
================================

Name: pipe_run_ctrl

Overview:
- Run-control sequencer for the 5-stage MIPS pipeline; sits beside the hazard unit and gates the whole pipeline from board buttons.
- Provides halt, free-run and single-instruction step.
- Stops fetch and then drains in-flight instructions, so the pipeline always halts on a retired-instruction boundary. Data memory and Leds can then be inspected via the Hack/DataMemAddr path.
- Keeps a running count of the cycles in which the pipeline was enabled.

Parameters:
- DRAIN_CYCLES, 4, cycles with fetch off and pipeline on needed to retire everything past IF (D,E,M,W); legal range 1..15.
- CNT_W, 32, width of CycleCnt.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- RunBtn  in  1  run request, debounced and synchronised level
- StepBtn  in  1  single-step request, debounced and synchronised level
- HaltBtn  in  1  halt request, debounced and synchronised level
- PCF  in  32  current fetch PC
- StallF  in  1  fetch stall from hazard unit
- BkptAddr  in  32  breakpoint PC (used only with the macro)
- PipeEn  out  1  global enable for the PC and all pipeline registers
- FetchEn  out  1  when 0, IF holds the PC (except a PCSrcD redirect) and IF/ID loads a NOP bubble
- Halted  out  1  1 while in HALTED
- RunState  out  2  HALTED=0, RUN=1, DRAIN=2, STEP=3
- CycleCnt  out  CNT_W  count of cycles with PipeEn=1
- BkptHit  out  1  sticky breakpoint flag (tied 0 without the macro)

Behaviour:
- Button edges:
  - Per button, a prev register stores the last level; edge = level & ~prev.
  - prev registers reset to 1, so a button held through reset produces no edge.
- State register and outputs (Moore, decoded from the registered state):
  - PipeEn = (state != HALTED).
  - FetchEn = (state == RUN) | (state == STEP).
  - Halted = (state == HALTED).
- Transitions, evaluated each rising clk:
  - HALTED: StepEdge -> STEP. Else RunEdge -> RUN. Else stay. Step wins when Run and Step edges coincide. HaltEdge is ignored.
  - RUN: HaltEdge, or breakpoint hit (macro only) -> DRAIN, drain counter loaded with DRAIN_CYCLES-1. Run and Step edges are ignored.
  - STEP: exactly one cycle, then unconditionally -> DRAIN, counter loaded with DRAIN_CYCLES-1. All edges are ignored. If StallF=1 during that cycle, nothing new is fetched and the step retires whatever was in flight; this is accepted behaviour.
  - DRAIN: counter decrements each cycle; when counter==0 -> HALTED. All button edges are ignored and not queued.
- Latency:
  - Edge sampled at clock edge t -> new state visible after edge t.
  - A step from HALTED gives PipeEn high for exactly 1+DRAIN_CYCLES cycles, with FetchEn high only in the first.
- CycleCnt:
  - +1 on every clock with PipeEn=1; wraps modulo 2^CNT_W with no saturation.
  - Cleared only by reset.
- Reset:
  - rst_n=0 sampled at any edge, including mid-DRAIN or mid-STEP, gives next state HALTED.
  - Reset also clears the drain counter, CycleCnt=0 and BkptHit=0, and sets prev registers=1.
  - All outputs then read HALTED values: PipeEn=0, FetchEn=0, Halted=1, RunState=0.
- Resume after halt: PC was held during DRAIN, so RUN or STEP continues from the first unfetched instruction. No instruction is lost or duplicated.

Optional Feature:
- Macro: PIPE_BREAKPOINT_EN.
- Hit condition: in RUN, hit = (PCF == BkptAddr) & ~StallF & PipeEn.
- The instruction at BkptAddr is fetched in the hit cycle and retires during DRAIN.
- BkptHit is set on a hit and cleared when the next RunEdge or StepEdge is accepted from HALTED.
- Resume does not re-hit, because PCF has advanced.
- A hit in the same cycle as a HaltEdge: both cause DRAIN, and BkptHit=1.
- Without the macro: no comparator is built, BkptHit is constant 0, and BkptAddr is unused.

Test Plan:
- Reset hold: rst_n=0 for 2 cycles with RunBtn=1 held; release rst_n.
  - Required: RunState=0, PipeEn=0, FetchEn=0, CycleCnt=0.
  - Required: state stays HALTED until RunBtn falls and rises again.
- Single step: StepBtn pulse from HALTED.
  - Required: 1 cycle STEP (FetchEn=1, PipeEn=1), then 4 cycles DRAIN (FetchEn=0, PipeEn=1), then HALTED.
  - Required: CycleCnt=5.
- Run/halt: RunBtn edge, 10 cycles in RUN, then HaltBtn edge.
  - Required: 4 DRAIN cycles, then HALTED.
  - Required: CycleCnt = RUN cycles (including the halt-sample cycle) + 4, checked exactly against the bench model.
- Simultaneous and ignored edges:
  - Run+Step edges on the same cycle in HALTED -> STEP.
  - Run or Halt edge during DRAIN -> no effect; HALTED after the remaining count.
  - Halt edge in HALTED -> stays HALTED.
- Breakpoint (PIPE_BREAKPOINT_EN), BkptAddr=0x10:
  - PCF stepping 0x0,0x4,0x8,0xC,0x10 with StallF=0 -> DRAIN on the cycle after PCF=0x10, and BkptHit=1.
  - Same sequence with StallF=1 while PCF=0x10 -> no hit until StallF drops.
  - Next RunEdge from HALTED -> BkptHit=0.
- Reset mid-operation: rst_n=0 during the 2nd DRAIN cycle.
  - Required: HALTED after the next edge, CycleCnt=0, drain restarts cleanly on the next step.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run-control sequencer for the 5-stage pipeline.
// Halt / free-run / single-step from button levels. Fetch stops first, then
// DRAIN_CYCLES cycles retire in-flight work so the pipe halts on an
// instruction boundary. Counts the cycles in which the pipeline was enabled.
// Optional macro PIPE_BREAKPOINT_EN adds a PC breakpoint comparator.
module pipe_run_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             RunBtn,
   input  logic             StepBtn,
   input  logic             HaltBtn,
   input  logic [31:0]      PCF,
   input  logic             StallF,
   input  logic [31:0]      BkptAddr,
   output logic             PipeEn,
   output logic             FetchEn,
   output logic             Halted,
   output logic [1:0]       RunState,
   output logic [CNT_W-1:0] CycleCnt,
   output logic             BkptHit
);

   localparam int unsigned DCNT_W = 4;
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

   localparam logic [1:0] HALTED = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] STEP   = 2'd3;

   logic [1:0]        state;
   logic [1:0]        stateNext;
   logic [DCNT_W-1:0] drainCnt;
   logic [DCNT_W-1:0] drainCntNext;
   logic              runPrev;
   logic              stepPrev;
   logic              haltPrev;
   logic              runEdge;
   logic              stepEdge;
   logic              haltEdge;
   logic              bkptHitNow;
   logic              bkptSet;
   logic              bkptClr;

   assign runEdge  = RunBtn  & ~runPrev;
   assign stepEdge = StepBtn & ~stepPrev;
   assign haltEdge = HaltBtn & ~haltPrev;

`ifdef PIPE_BREAKPOINT_EN
   // Hit when the breakpoint PC is actually fetched while free-running.
   assign bkptHitNow = (state == RUN) & (PCF == BkptAddr) & ~StallF & PipeEn;
`else
   logic unusedBkptInputs;
   assign bkptHitNow       = 1'b0;
   assign unusedBkptInputs = ^{PCF, StallF, BkptAddr};
`endif

   // Next-state and drain-counter decode.
   always_comb begin
      stateNext    = state;
      drainCntNext = drainCnt;
      bkptSet      = 1'b0;
      bkptClr      = 1'b0;
      case (state)
         HALTED: begin
            if (stepEdge) begin
               stateNext = STEP;
               bkptClr   = 1'b1;
            end else if (runEdge) begin
               stateNext = RUN;
               bkptClr   = 1'b1;
            end
         end
         RUN: begin
            if (haltEdge | bkptHitNow) begin
               stateNext    = DRAIN;
               drainCntNext = DRAIN_LOAD;
               bkptSet      = bkptHitNow;
            end
         end
         STEP: begin
            stateNext    = DRAIN;
            drainCntNext = DRAIN_LOAD;
         end
         DRAIN: begin
            if (drainCnt == '0) begin
               stateNext = HALTED;
            end else begin
               drainCntNext = drainCnt - DCNT_W'(1);
            end
         end
         default: stateNext = HALTED;
      endcase
   end

   // State register with outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= HALTED;
         drainCnt <= '0;
         RunState <= HALTED;
         PipeEn   <= 1'b0;
         FetchEn  <= 1'b0;
         Halted   <= 1'b1;
      end else begin
         state    <= stateNext;
         drainCnt <= drainCntNext;
         RunState <= stateNext;
         PipeEn   <= (stateNext != HALTED);
         FetchEn  <= (stateNext == RUN) | (stateNext == STEP);
         Halted   <= (stateNext == HALTED);
      end
   end

   // Button level history; reset high so a held button gives no edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         runPrev  <= 1'b1;
         stepPrev <= 1'b1;
         haltPrev <= 1'b1;
      end else begin
         runPrev  <= RunBtn;
         stepPrev <= StepBtn;
         haltPrev <= HaltBtn;
      end
   end

   // Enabled-cycle counter, free-wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         CycleCnt <= '0;
      end else if (PipeEn) begin
         CycleCnt <= CycleCnt + CNT_W'(1);
      end
   end

   // Sticky breakpoint flag, cleared when a new run or step is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         BkptHit <= 1'b0;
      end else if (bkptSet) begin
         BkptHit <= 1'b1;
      end else if (bkptClr) begin
         BkptHit <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb_pipe_run_ctrl: scoreboard bench for pipe_run_ctrl. The reference model
// schedules future states in a plan queue from the button rules.
module tb_pipe_run_ctrl;

   localparam int unsigned DRAIN = 4;

   typedef struct packed {
      logic [1:0]  runState;
      logic        pipeEn;
      logic        fetchEn;
      logic        halted;
      logic        bkptHit;
      logic [31:0] cycleCnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RunBtn = 1'b0, StepBtn = 1'b0, HaltBtn = 1'b0;
   logic [31:0] PCF = '0;
   logic        StallF = 1'b0;
   logic [31:0] BkptAddr = 32'h40;
   logic        PipeEn, FetchEn, Halted, BkptHit;
   logic [1:0]  RunState;
   logic [31:0] CycleCnt;

   pipe_run_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .RunBtn(RunBtn), .StepBtn(StepBtn),
      .HaltBtn(HaltBtn), .PCF(PCF), .StallF(StallF), .BkptAddr(BkptAddr),
      .PipeEn(PipeEn), .FetchEn(FetchEn), .Halted(Halted),
      .RunState(RunState), .CycleCnt(CycleCnt), .BkptHit(BkptHit)
   );

   always #5 clk = ~clk;

   exp_t expQ[$];
   int   nCompared = 0;
   int   nMismatched = 0;

   // Reference model state.
   int          mMode = 0;
   int          mPlan[$];
   logic [31:0] mCnt = '0;
   bit          mBk = 1'b0;
   bit          mPr = 1'b1, mPs = 1'b1, mPh = 1'b1;

   // Applies one sampled clock edge to the model and returns expected outputs.
   task automatic modelEdge(input bit r, s, h, rn, input logic [31:0] pc,
                            input bit st, input logic [31:0] ba, output exp_t e);
      bit re, se, he, hit;
      if (!rn) begin
         mMode = 0; mPlan.delete(); mCnt = '0; mBk = 0;
         mPr = 1; mPs = 1; mPh = 1;
      end else begin
         re = r & ~mPr; se = s & ~mPs; he = h & ~mPh;
         if (mMode != 0) mCnt = mCnt + 32'd1;
         if (mPlan.size() > 0) begin
            mMode = mPlan.pop_front();
         end else if (mMode == 0) begin
            if (se) begin
               mMode = 3; mBk = 0;
               for (int i = 0; i < DRAIN; i++) mPlan.push_back(2);
               mPlan.push_back(0);
            end else if (re) begin
               mMode = 1; mBk = 0;
            end
         end else if (mMode == 1) begin
            hit = 0;
`ifdef PIPE_BREAKPOINT_EN
            hit = (pc == ba) && !st;
`endif
            if (hit) mBk = 1;
            if (he || hit) begin
               mMode = 2;
               for (int i = 1; i < DRAIN; i++) mPlan.push_back(2);
               mPlan.push_back(0);
            end
         end
         mPr = r; mPs = s; mPh = h;
      end
      e.runState = 2'(mMode);
      e.pipeEn   = (mMode != 0);
      e.fetchEn  = (mMode == 1) || (mMode == 3);
      e.halted   = (mMode == 0);
      e.bkptHit  = mBk;
      e.cycleCnt = mCnt;
   endtask

   // One cycle of stimulus: drive at negedge, predict, enqueue.
   task automatic tick(input bit r, s, h, rn);
      exp_t e;
      @(negedge clk);
      RunBtn = r; StepBtn = s; HaltBtn = h; rst_n = rn;
      modelEdge(r, s, h, rn, PCF, StallF, BkptAddr, e);
      expQ.push_back(e);
   endtask

   task automatic hold(input bit r, s, h, input int n);
      for (int i = 0; i < n; i++) tick(r, s, h, 1'b1);
   endtask

   // Monitor: compare DUT outputs just after each active edge.
   initial begin
      exp_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            g = {RunState, PipeEn, FetchEn, Halted, BkptHit, CycleCnt};
            nCompared++;
            if (g !== e) begin
               nMismatched++;
               $display("FAIL outputs t=%0t got st=%0d pe=%0b fe=%0b h=%0b bk=%0b cnt=%0d required st=%0d pe=%0b fe=%0b h=%0b bk=%0b cnt=%0d",
                        $time, g.runState, g.pipeEn, g.fetchEn, g.halted, g.bkptHit, g.cycleCnt,
                        e.runState, e.pipeEn, e.fetchEn, e.halted, e.bkptHit, e.cycleCnt);
            end
         end
      end
   end

   initial begin
      // Reset with RunBtn held: no edge after release until it re-rises.
      tick(1, 0, 0, 0); tick(1, 0, 0, 0);
      hold(1, 0, 0, 3);
      hold(0, 0, 0, 1);
      hold(1, 0, 0, 1);
      hold(0, 0, 0, 9);
      hold(0, 0, 1, 1);
      hold(0, 0, 0, 6);
      // Single step.
      hold(0, 1, 0, 1);
      hold(0, 0, 0, 7);
      // Run+Step together, then ignored edges in DRAIN and Halt in HALTED.
      hold(1, 1, 0, 1);
      hold(0, 0, 0, 2);
      hold(1, 0, 1, 1);
      hold(0, 0, 0, 5);
      hold(0, 0, 1, 1);
      hold(0, 0, 0, 2);
      // Breakpoint at 0x10, with a stall on the hit address first.
      BkptAddr = 32'h10; PCF = 32'h0;
      hold(1, 0, 0, 1);
      PCF = 32'h4; hold(0, 0, 0, 1);
      PCF = 32'h8; hold(0, 0, 0, 1);
      PCF = 32'hC; hold(0, 0, 0, 1);
      PCF = 32'h10; StallF = 1'b1; hold(0, 0, 0, 2);
      StallF = 1'b0; hold(0, 0, 0, 1);
      PCF = 32'h14; hold(0, 0, 0, 6);
      hold(0, 0, 1, 1);
      hold(0, 0, 0, 6);
      hold(1, 0, 0, 1);
      PCF = 32'h18; hold(0, 0, 0, 3);
      hold(0, 0, 1, 1);
      hold(0, 0, 0, 6);
      // Reset during the second DRAIN cycle, then a clean step.
      hold(0, 1, 0, 1);
      hold(0, 0, 0, 2);
      tick(0, 0, 0, 0);
      hold(0, 1, 0, 1);
      hold(0, 0, 0, 7);
      // Randomised phase.
      for (int i = 0; i < 3000; i++) begin
         PCF = 32'($urandom_range(0, 7)) * 32'd4;
         StallF = ($urandom_range(0, 3) == 0);
         tick((RunBtn  ^ ($urandom_range(0, 5) == 0)),
              (StepBtn ^ ($urandom_range(0, 7) == 0)),
              (HaltBtn ^ ($urandom_range(0, 5) == 0)),
              ($urandom_range(0, 199) != 0));
      end
      repeat (3) @(negedge clk);
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("FAIL drain_queue got %0d pending required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
